// File: rtl/video_capture.sv
// video_capture: deserialises a serial TTL video stream into byte writes for a
// frame buffer, framed by active-low hsync/vsync with optional porch skipping.
module video_capture #(
  parameter int unsigned H_ACTIVE = 512,
  parameter int unsigned V_ACTIVE = 342,
  parameter int unsigned H_SKIP   = 0,
  parameter int unsigned V_SKIP   = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        pix_en,
  input  logic        vid,
  input  logic        n_hsync,
  input  logic        n_vsync,
  output logic [7:0]  wr_data,
  output logic [14:0] wr_addr,
  output logic        wr_en,
  output logic        frame_done,
  output logic        line_err,
  output logic        frame_err
);

  localparam int unsigned PIX_W  = $clog2(H_ACTIVE + 1);
  localparam int unsigned LINE_W = $clog2(V_ACTIVE + 1);
  localparam int unsigned HS_W   = $clog2(H_SKIP + 2);
  localparam int unsigned VS_W   = $clog2(V_SKIP + 2);

  localparam logic [PIX_W-1:0]  PIX_LAST   = PIX_W'(H_ACTIVE - 1);
  localparam logic [LINE_W-1:0] LINE_LAST  = LINE_W'(V_ACTIVE - 1);
  localparam logic [HS_W-1:0]   HSKIP_LAST = HS_W'((H_SKIP == 0) ? 0 : H_SKIP - 1);
  localparam logic [VS_W-1:0]   VSKIP_LAST = VS_W'(V_SKIP);
  localparam logic [14:0]       BPL        = 15'(H_ACTIVE / 8);

  typedef enum logic [2:0] {IDLE, VBLANK, HPORCH, ACTIVE, HWAIT} state_t;

  // With no horizontal skip the porch state is bypassed entirely.
  localparam state_t LINE_ENTRY = (H_SKIP == 0) ? ACTIVE : HPORCH;

  state_t state, state_next;

  logic              hs_q, vs_q;
  logic [VS_W-1:0]   skip_cnt;
  logic [HS_W-1:0]   hskip_cnt;
  logic [PIX_W-1:0]  pix_cnt;
  logic [LINE_W-1:0] line_cnt;
  logic [6:0]        byte_sr;
  logic [14:0]       line_base;
  logic [14:0]       addr_cnt;

  logic hs_edge, vs_edge, last_line;
  logic frame_start, frame_abort, skip_inc, line_start, hskip_inc;
  logic shift_en, byte_done, line_adv, line_abort;

  assign hs_edge   = hs_q & ~n_hsync;
  assign vs_edge   = vs_q & ~n_vsync;
  assign last_line = (line_cnt == LINE_LAST);

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    skip_inc    = 1'b0;
    line_start  = 1'b0;
    hskip_inc   = 1'b0;
    shift_en    = 1'b0;
    byte_done   = 1'b0;
    line_adv    = 1'b0;
    line_abort  = 1'b0;

    if (state == IDLE) begin
      if (vs_edge && en) begin
        state_next  = VBLANK;
        frame_start = 1'b1;
      end
    end else if (vs_edge) begin
      // vsync outranks any hsync edge in the same cycle
      state_next  = VBLANK;
      frame_start = 1'b1;
      frame_abort = 1'b1;
    end else if ((state == HPORCH || state == ACTIVE) && hs_edge) begin
      // The aborting edge doubles as the start of the next line.
      line_abort = 1'b1;
      line_adv   = 1'b1;
      line_start = 1'b1;
      state_next = last_line ? IDLE : LINE_ENTRY;
    end else begin
      case (state)
        VBLANK: begin
          if (hs_edge) begin
            if (skip_cnt == VSKIP_LAST) begin
              line_start = 1'b1;
              state_next = LINE_ENTRY;
            end else begin
              skip_inc = 1'b1;
            end
          end
        end
        HPORCH: begin
          if (pix_en) begin
            if (hskip_cnt == HSKIP_LAST) state_next = ACTIVE;
            else                         hskip_inc  = 1'b1;
          end
        end
        ACTIVE: begin
          if (pix_en) begin
            shift_en  = 1'b1;
            byte_done = (pix_cnt[2:0] == 3'b111);
            if (pix_cnt == PIX_LAST) begin
              line_adv   = 1'b1;
              state_next = last_line ? IDLE : HWAIT;
            end
          end
        end
        HWAIT: begin
          if (hs_edge) begin
            line_start = 1'b1;
            state_next = LINE_ENTRY;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      skip_cnt   <= '0;
      hskip_cnt  <= '0;
      pix_cnt    <= '0;
      line_cnt   <= '0;
      byte_sr    <= '0;
      line_base  <= '0;
      addr_cnt   <= '0;
      wr_data    <= '0;
      wr_addr    <= '0;
      wr_en      <= 1'b0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_next;
      hs_q       <= n_hsync;
      vs_q       <= n_vsync;
      wr_en      <= byte_done;
      frame_done <= line_adv & last_line;
      line_err   <= line_abort;
      frame_err  <= frame_abort;

      if (byte_done) begin
        wr_data <= {byte_sr, vid};
        wr_addr <= addr_cnt;
      end

      if (frame_start) begin
        skip_cnt  <= '0;
        hskip_cnt <= '0;
        pix_cnt   <= '0;
        line_cnt  <= '0;
        byte_sr   <= '0;
        line_base <= '0;
        addr_cnt  <= '0;
      end else begin
        if (skip_inc)  skip_cnt  <= skip_cnt + 1'b1;
        if (hskip_inc) hskip_cnt <= hskip_cnt + 1'b1;
        if (shift_en) begin
          byte_sr <= {byte_sr[5:0], vid};
          pix_cnt <= pix_cnt + 1'b1;
        end
        if (byte_done) addr_cnt <= addr_cnt + 1'b1;
        // Line advance re-bases the address so aborted lines never shift later lines.
        if (line_adv) begin
          line_cnt  <= line_cnt + 1'b1;
          line_base <= line_base + BPL;
          addr_cnt  <= line_base + BPL;
        end
        if (line_start) begin
          hskip_cnt <= '0;
          pix_cnt   <= '0;
          byte_sr   <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_video_capture.sv
// Directed bench for video_capture: line-vector table for clean frames plus
// hand-written sequences for latency, aborts, simultaneous syncs and reset.
module tb_video_capture;

  localparam int unsigned H_ACTIVE = 16;
  localparam int unsigned V_ACTIVE = 3;
  localparam int unsigned H_SKIP   = 2;
  localparam int unsigned V_SKIP   = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        pix_en = 1'b0;
  logic        vid = 1'b0;
  logic        n_hsync = 1'b1;
  logic        n_vsync = 1'b1;
  logic [7:0]  wr_data;
  logic [14:0] wr_addr;
  logic        wr_en, frame_done, line_err, frame_err;

  video_capture #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .H_SKIP(H_SKIP),
    .V_SKIP(V_SKIP)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .pix_en(pix_en), .vid(vid),
    .n_hsync(n_hsync), .n_vsync(n_vsync),
    .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .frame_done(frame_done), .line_err(line_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [14:0] addr;
    logic [7:0]  data;
    logic        fd;
  } wr_t;

  typedef struct {
    logic        new_frame;
    logic        en_after;
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [14:0] addr0;
    logic        fd;
  } line_vec_t;

  wr_t         wq[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned fd_cnt = 0;
  int unsigned le_cnt = 0;
  int unsigned fe_cnt = 0;

  always @(negedge clk) begin
    if (wr_en === 1'b1) wq.push_back('{wr_addr, wr_data, frame_done});
    if (frame_done === 1'b1) fd_cnt++;
    if (line_err === 1'b1) le_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_wr(input string name, input int unsigned idx,
                           input logic [14:0] addr, input logic [7:0] data, input logic fd);
    if (idx < wq.size()) begin
      chk({name, "_addr"}, 32'(wq[idx].addr), 32'(addr));
      chk({name, "_data"}, 32'(wq[idx].data), 32'(data));
      chk({name, "_fd"},   32'(wq[idx].fd),   32'(fd));
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: write %0d missing, got %0d writes", name, idx, wq.size());
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hsync_pulse();
    n_hsync = 1'b0; tick();
    n_hsync = 1'b1; tick();
  endtask

  task automatic vsync_pulse();
    n_vsync = 1'b0; tick();
    n_vsync = 1'b1; tick();
  endtask

  task automatic send_pix(input logic b);
    pix_en = 1'b1; vid = b; tick();
    pix_en = 1'b0; vid = 1'b0;
  endtask

  task automatic send_bits(input logic [7:0] b, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) send_pix(b[7-i]);
  endtask

  task automatic line_head();
    hsync_pulse();
    send_pix(1'b1);
    send_pix(1'b0);
  endtask

  task automatic send_line(input logic [7:0] b0, input logic [7:0] b1);
    line_head();
    send_bits(b0, 8);
    send_bits(b1, 8);
    tick(); tick();
  endtask

  task automatic start_frame();
    en = 1'b1;
    vsync_pulse();
    hsync_pulse();
  endtask

  task automatic check_idle_outputs(input string name);
    chk({name, "_wr_en"},      32'(wr_en),      32'd0);
    chk({name, "_frame_done"}, 32'(frame_done), 32'd0);
    chk({name, "_line_err"},   32'(line_err),   32'd0);
    chk({name, "_frame_err"},  32'(frame_err),  32'd0);
    chk({name, "_wr_data"},    32'(wr_data),    32'd0);
    chk({name, "_wr_addr"},    32'(wr_addr),    32'd0);
  endtask

  initial begin
    line_vec_t   vecs[6];
    int unsigned base, fd0, le0, fe0;

    vecs[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 15'd0, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 15'd2, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 8'hA5, 8'h3C, 15'd4, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 8'hFF, 8'h00, 15'd0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h01, 8'h80, 15'd2, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 8'h5A, 8'hC3, 15'd4, 1'b1};

    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    tick();

    // Clean frames; the second drops en right after the frame starts.
    for (int unsigned i = 0; i < 6; i++) begin
      if (vecs[i].new_frame) begin
        en = 1'b1;
        vsync_pulse();
        en = vecs[i].en_after;
        hsync_pulse();
      end
      base = wq.size();
      fd0  = fd_cnt;
      send_line(vecs[i].b0, vecs[i].b1);
      chk("vec_nwrites", wq.size() - base, 32'd2);
      expect_wr("vec_w0", base,     vecs[i].addr0,        vecs[i].b0, 1'b0);
      expect_wr("vec_w1", base + 1, vecs[i].addr0 + 15'd1, vecs[i].b1, vecs[i].fd);
      chk("vec_fd_cnt", fd_cnt - fd0, 32'(vecs[i].fd));
    end
    chk("clean_le", le_cnt, 32'd0);
    chk("clean_fe", fe_cnt, 32'd0);

    // Latency: write strobe appears in the cycle after the 8th pixel.
    start_frame();
    base = wq.size();
    line_head();
    send_bits(8'hC3, 7);
    pix_en = 1'b1; vid = 1'b1;
    @(negedge clk);
    chk("lat_before", 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    pix_en = 1'b0; vid = 1'b0;
    @(negedge clk);
    chk("lat_wr_en", 32'(wr_en),   32'd1);
    chk("lat_addr",  32'(wr_addr), 32'd0);
    chk("lat_data",  32'(wr_data), 32'hC3);
    @(negedge clk);
    chk("lat_pulse", 32'(wr_en), 32'd0);
    send_bits(8'h11, 8);
    tick(); tick();
    send_line(8'h22, 8'h33);
    send_line(8'h44, 8'h55);
    chk("lat_nwrites", wq.size() - base, 32'd6);
    expect_wr("lat_last", base + 5, 15'd5, 8'h55, 1'b1);

    // Short line: hsync after 11 active pixels on line 0.
    start_frame();
    base = wq.size(); fd0 = fd_cnt; le0 = le_cnt; fe0 = fe_cnt;
    line_head();
    send_bits(8'hA5, 8);
    send_bits(8'h3C, 3);
    hsync_pulse();
    send_pix(1'b1);
    send_pix(1'b1);
    send_bits(8'h0F, 8);
    send_bits(8'hF0, 8);
    tick(); tick();
    chk("short_nwrites", wq.size() - base, 32'd3);
    chk("short_le", le_cnt - le0, 32'd1);
    chk("short_fd_mid", fd_cnt - fd0, 32'd0);
    expect_wr("short_w0", base,     15'd0, 8'hA5, 1'b0);
    expect_wr("short_w1", base + 1, 15'd2, 8'h0F, 1'b0);
    expect_wr("short_w2", base + 2, 15'd3, 8'hF0, 1'b0);
    send_line(8'h12, 8'h34);
    expect_wr("short_w4", base + 4, 15'd5, 8'h34, 1'b1);
    chk("short_fe", fe_cnt - fe0, 32'd0);

    // Frame restart: vsync arrives part-way through line 1.
    start_frame();
    base = wq.size(); fd0 = fd_cnt; fe0 = fe_cnt;
    send_line(8'h11, 8'h22);
    line_head();
    send_bits(8'hFF, 5);
    vsync_pulse();
    chk("restart_fe", fe_cnt - fe0, 32'd1);
    chk("restart_fd", fd_cnt - fd0, 32'd0);
    chk("restart_nwrites", wq.size() - base, 32'd2);
    hsync_pulse();
    send_line(8'h77, 8'h88);
    expect_wr("restart_w0", base + 2, 15'd0, 8'h77, 1'b0);
    expect_wr("restart_w1", base + 3, 15'd1, 8'h88, 1'b0);
    send_line(8'h99, 8'hAA);
    send_line(8'hBB, 8'hCC);
    chk("restart_fd_end", fd_cnt - fd0, 32'd1);

    // Simultaneous vsync and hsync: that hsync must not count as a skip.
    base = wq.size();
    en = 1'b1;
    n_vsync = 1'b0; n_hsync = 1'b0; tick();
    n_vsync = 1'b1; n_hsync = 1'b1; tick();
    hsync_pulse();
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 2);
    tick();
    chk("simul_skipped", wq.size() - base, 32'd0);
    send_line(8'h6B, 8'hD2);
    expect_wr("simul_w0", base,     15'd0, 8'h6B, 1'b0);
    expect_wr("simul_w1", base + 1, 15'd1, 8'hD2, 1'b0);
    send_line(8'h01, 8'h02);
    send_line(8'h03, 8'h04);
    expect_wr("simul_w5", base + 5, 15'd5, 8'h04, 1'b1);

    // Reset mid-byte with pixel and sync activity, then en=0 afterwards.
    start_frame();
    base = wq.size(); fd0 = fd_cnt; le0 = le_cnt; fe0 = fe_cnt;
    line_head();
    send_bits(8'hFF, 5);
    rst = 1'b1; pix_en = 1'b1; vid = 1'b1;
    n_hsync = 1'b0; tick();
    n_hsync = 1'b1; n_vsync = 1'b0; tick();
    n_vsync = 1'b1; tick();
    tick();
    @(negedge clk);
    check_idle_outputs("rst_hold");
    pix_en = 1'b0; vid = 1'b0;
    tick();
    rst = 1'b0; en = 1'b0;
    vsync_pulse();
    hsync_pulse();
    hsync_pulse();
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 8);
    send_bits(8'hFF, 4);
    tick();
    @(negedge clk);
    check_idle_outputs("rst_after");
    chk("rst_nwrites", wq.size() - base, 32'd0);
    chk("rst_fd", fd_cnt - fd0, 32'd0);
    chk("rst_le", le_cnt - le0, 32'd0);
    chk("rst_fe", fe_cnt - fe0, 32'd0);
    tick();
    start_frame();
    send_line(8'hE7, 8'h18);
    expect_wr("rst_resume_w0", base, 15'd0, 8'hE7, 1'b0);
    send_line(8'h24, 8'h42);
    send_line(8'h81, 8'h7E);
    expect_wr("rst_resume_w5", base + 5, 15'd5, 8'h7E, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_capture.md
VIDEO_CAPTURE -- requirements
Module: video_capture

Interface
REQ-001 SHALL have these parameters:
- H_ACTIVE, 512: active pixels per line; a multiple of 8.
- V_ACTIVE, 342: active lines per frame.
- H_SKIP, 0: pix_en pulses ignored after each line-start n_hsync falling edge.
- V_SKIP, 0: n_hsync falling edges ignored after an n_vsync falling edge.
- (H_ACTIVE/8)*V_ACTIVE SHALL NOT exceed 32768.

REQ-002 SHALL have these ports:
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  capture enable; sampled only in IDLE.
- pix_en  in  1  one serial pixel valid this cycle.
- vid  in  1  serial TTL video bit.
- n_hsync  in  1  active-low horizontal sync.
- n_vsync  in  1  active-low vertical sync.
- wr_data  out  8  deserialized byte; the first pixel of the byte is in bit 7.
- wr_addr  out  15  byte address = line*(H_ACTIVE/8) + byte index.
- wr_en  out  1  one-cycle write strobe.
- frame_done  out  1  one-cycle pulse when a full frame has been written.
- line_err  out  1  one-cycle pulse when a line is aborted.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

REQ-003 SHALL treat all inputs as synchronous to clk, with no internal synchronizers.

Function
REQ-004 SHALL detect a sync falling edge as previous-sample=1 and current-sample=0, using one registered sample per sync input.
REQ-005 SHALL implement these states: IDLE, VBLANK, HPORCH, ACTIVE, HWAIT.
REQ-006 In IDLE, a vsync edge while en=1 SHALL go to VBLANK and clear the line counter, the skip counter and the byte index.
REQ-007 In VBLANK, each hsync edge SHALL increment the skip counter, and the hsync edge that arrives with the counter equal to V_SKIP SHALL go to HPORCH as line 0.
REQ-008 In HPORCH, the FSM SHALL count pix_en pulses, enter ACTIVE once H_SKIP pulses have been counted, and enter ACTIVE immediately when H_SKIP=0.
REQ-009 In ACTIVE, each pix_en SHALL shift vid into the byte register MSB-first and increment the pixel counter.
REQ-010 On the cycle carrying the 8th pixel of a byte, the block SHALL register the byte.
REQ-011 wr_en SHALL be high on the next cycle with wr_data and wr_addr valid, so latency is 1 clk after the 8th pix_en.
REQ-012 After the H_ACTIVE-th pixel, the line counter SHALL increment.
REQ-013 If the new line count equals V_ACTIVE, frame_done SHALL pulse in the same cycle as the final wr_en and the FSM SHALL go to IDLE; otherwise the FSM SHALL go to HWAIT.
REQ-014 In HWAIT, pix_en SHALL be ignored and an hsync edge SHALL go to HPORCH.
REQ-015 An hsync edge in HPORCH or ACTIVE SHALL pulse line_err and discard the partial byte with no wr_en.
REQ-016 After such an abort, the line counter SHALL advance by 1 and the FSM SHALL go to HPORCH for the next line, or to IDLE with frame_done if V_ACTIVE is reached.
REQ-017 A vsync edge in any state except IDLE SHALL pulse frame_err, clear all counters and go to VBLANK, with no frame_done.
REQ-018 A vsync edge and an hsync edge in the same cycle: vsync SHALL take priority and that hsync edge SHALL NOT be counted in VBLANK.
REQ-019 en=0 SHALL have no effect outside IDLE; the current frame SHALL complete.
REQ-020 wr_addr SHALL never wrap within a frame; byte 0 of line L SHALL be at L*(H_ACTIVE/8).

Reset
REQ-021 While rst=1 at a clk edge, the block SHALL enter IDLE and clear all counters and the byte register.
REQ-022 While rst=1, wr_en, frame_done, line_err and frame_err SHALL be 0, and wr_data and wr_addr SHALL be 0.
REQ-023 Both sync sample registers SHALL load 1, so that sync held low through reset produces no edge.
REQ-024 rst SHALL override every input in the same cycle, including mid-byte and mid-frame; there SHALL be no wr_en for a partial byte.

Verification (H_ACTIVE=16, V_ACTIVE=3, H_SKIP=2, V_SKIP=1 unless noted)
REQ-025 Clean frame: the bench SHALL check the following.
- Stimulus: vsync edge, 1 skipped hsync, then 3 lines with the pattern 0xA5,0x3C per line.
- Response: 6 wr_en pulses; addr 0..5; data A5,3C,A5,3C,A5,3C; frame_done coincident with the write at addr 5.
REQ-026 Latency: the bench SHALL check that the 8th pix_en of the first byte at cycle N produces wr_en=1 at cycle N+1, with wr_addr=0.
REQ-027 Short line: the bench SHALL check the following.
- Stimulus: an hsync edge after 11 active pixels on line 0.
- Response: one write (addr 0), line_err=1, no write for the partial byte, next line written at addr 2,3.
REQ-028 Frame restart: the bench SHALL check the following.
- Stimulus: a vsync edge during line 1.
- Response: frame_err=1, no frame_done; the new frame restarts writes at addr 0.
REQ-029 Simultaneous sync: the bench SHALL check the following.
- Stimulus: vsync and hsync fall in the same cycle.
- Response: 1 further hsync edge is skipped, and line 0 begins on the 2nd subsequent hsync edge.
REQ-030 Reset mid-byte: the bench SHALL check the following.
- Stimulus: rst after 5 pixels, then rst deasserted with en=0 and sync activity.
- Response: all outputs 0, state IDLE, no wr_en.
